// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM state and complex sample type for the FFT output unit
package fft_pkg;
    localparam int FFT_N      = 64;
    localparam int FFT_ADDR_W = 6;
    localparam int FFT_DATA_W = 32;
    typedef enum logic {FILL, DRAIN} state_t;
    typedef struct packed {
        logic [FFT_DATA_W-1:0] re;
        logic [FFT_DATA_W-1:0] im;
    } cplx_t;
endpackage

// File: rtl/fft_out_ram.sv
// fft_out_ram: frame buffer, both halves written together (k and k+N/2), async read
module fft_out_ram import fft_pkg::*; #(
    parameter int DW = 2*FFT_DATA_W,
    parameter int AW = FFT_ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-2:0] wa,
    input  logic [DW-1:0] wd_lo,
    input  logic [DW-1:0] wd_hi,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{1'b0, wa}] <= wd_lo;
            mem[{1'b1, wa}] <= wd_hi;
        end
    end
    assign rd = mem[ra];
endmodule

// File: rtl/fft_output_unit.sv
// fft_output_unit: collects butterfly result pairs into a frame buffer and streams it out;
// FFT_OUT_BITREV_EN selects bit-reversed read addressing (natural frequency order).
module fft_output_unit import fft_pkg::*; #(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N      = FFT_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pair_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in_first_re,
    input  logic [DATA_W-1:0] data_in_first_im,
    input  logic [DATA_W-1:0] data_in_second_re,
    input  logic [DATA_W-1:0] data_in_second_im,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] data_out_re,
    output logic [DATA_W-1:0] data_out_im,
    output logic              dout_last,
    output logic              drop_err
);
    localparam int AW = $clog2(N);
    localparam logic [AW:0] RD_END  = (AW+1)'(N);
    localparam logic [AW:0] RD_LAST = (AW+1)'(N-1);
    state_t              state, state_next;
    logic [AW-2:0]       wr_cnt;
    logic [AW:0]         rd_cnt;
    logic [AW-1:0]       rd_addr;
    logic [2*DATA_W-1:0] rd_data;
    logic                accept, fetch, last_xfer;
    assign in_ready = (state == FILL);
    always_comb begin
        accept     = pair_valid && in_ready;
        fetch      = (state == DRAIN) && (rd_cnt != RD_END) && (!dout_valid || dout_ready);
        last_xfer  = dout_valid && dout_ready && dout_last;
        state_next = (accept && &wr_cnt) ? DRAIN : (last_xfer ? FILL : state);
    end
`ifdef FFT_OUT_BITREV_EN
    always_comb begin
        rd_addr = '0;
        for (int b = 0; b < AW; b++) rd_addr[b] = rd_cnt[AW-1-b];
    end
`else
    assign rd_addr = rd_cnt[AW-1:0];
`endif
    fft_out_ram #(.DW(2*DATA_W), .AW(AW)) u_ram (
        .clk  (clk),
        .we   (accept),
        .wa   (wr_cnt),
        .wd_lo({data_in_first_re, data_in_first_im}),
        .wd_hi({data_in_second_re, data_in_second_im}),
        .ra   (rd_addr),
        .rd   (rd_data)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
            data_out_re <= '0;
            data_out_im <= '0;
            drop_err    <= 1'b0;
        end else begin
            if (pair_valid && !in_ready) drop_err <= 1'b1;
            if (accept) wr_cnt <= wr_cnt + 1'b1;
            // the final transfer ends the frame; rd_cnt has already reached N so no fetch competes
            if (last_xfer) begin
                rd_cnt     <= '0;
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end else if (fetch) begin
                {data_out_re, data_out_im} <= rd_data;
                dout_valid <= 1'b1;
                dout_last  <= (rd_cnt == RD_LAST);
                rd_cnt     <= rd_cnt + 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_output_unit.sv
// tb_fft_output_unit: frame-level model of the output unit, checked every cycle, plus literal pins
module tb_fft_output_unit;
    import fft_pkg::*;
    logic        clk = 1'b0, rst = 1'b1, pair_valid = 1'b0, dout_ready = 1'b1;
    logic [31:0] first_re = '0, first_im = '0, second_re = '0, second_im = '0;
    logic        in_ready, dout_valid, dout_last, drop_err;
    logic [31:0] data_out_re, data_out_im;
    int total = 0, bad = 0;
    bit run = 0, m_fill = 1, gap = 0, chk_zero = 1, m_drop = 0, hold = 0, ev, held_last;
    int cnt = 0, nout = 0, frames = 0;
    cplx_t buf_m [64];
    cplx_t q [$];
    cplx_t held;
    logic [31:0] cap [64];
    always #5 clk = ~clk;
    fft_output_unit dut (
        .clk(clk), .rst(rst), .pair_valid(pair_valid), .in_ready(in_ready),
        .data_in_first_re(first_re), .data_in_first_im(first_im),
        .data_in_second_re(second_re), .data_in_second_im(second_im),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .data_out_re(data_out_re), .data_out_im(data_out_im),
        .dout_last(dout_last), .drop_err(drop_err)
    );
    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction
    function automatic int addr_of(input int i);
        logic [5:0] a, r;
        a = 6'(i);
        for (int b = 0; b < 6; b++) r[b] = a[5-b];
`ifdef FFT_OUT_BITREV_EN
        return int'(r);
`else
        return int'(a);
`endif
    endfunction
    // model: frame stored as accepted, then emitted as a queue after a one-cycle gap
    always @(negedge clk) begin
        if (run) begin
            ev = !m_fill && !gap && q.size() > 0;
            if (chk_zero) begin
                chk("reset_data", {data_out_re, data_out_im}, 64'd0);
                chk("reset_last", dout_last, 1'b0);
                chk_zero = 0;
            end
            chk("in_ready", in_ready, m_fill);
            chk("dout_valid", dout_valid, ev);
            chk("drop_err", drop_err, m_drop);
            if (hold) begin
                chk("stall_data", {data_out_re, data_out_im}, held);
                chk("stall_last", dout_last, held_last);
            end
            if (ev) chk("dout_last", dout_last, q.size() == 1);
            else    chk("idle_last", dout_last, 1'b0);
            if (ev && dout_ready) chk("data", {data_out_re, data_out_im}, q[0]);
            hold = ev && !dout_ready;
            held = {data_out_re, data_out_im};
            held_last = dout_last;
            if (rst) begin
                m_fill = 1; cnt = 0; q.delete(); m_drop = 0; gap = 0; chk_zero = 1; hold = 0;
            end else begin
                gap = 0;
                if (pair_valid) begin
                    if (m_fill) begin
                        buf_m[cnt]    = {first_re, first_im};
                        buf_m[cnt+32] = {second_re, second_im};
                        cnt++;
                        if (cnt == 32) begin
                            cnt = 0; m_fill = 0; gap = 1;
                            for (int i = 0; i < 64; i++) q.push_back(buf_m[addr_of(i)]);
                        end
                    end else m_drop = 1;
                end
                if (ev && dout_ready) begin
                    if (frames == 0) cap[nout] = data_out_re;
                    nout++;
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_fill = 1; frames++; nout = 0;
                    end
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_pair(input int v);
        first_re  = 32'(v);
        first_im  = 32'(-v);
        second_re = 32'(v + 32);
        second_im = 32'(-(v + 32));
    endtask
    task automatic send(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            pair_valid = 1'b1;
            set_pair(base + k);
            tick();
        end
        pair_valid = 1'b0;
    endtask
    task automatic wait_drain(input int budget, input bit toggle);
        int c = 0;
        while (!(m_fill && q.size() == 0) && c < budget) begin
            dout_ready = toggle ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            tick();
            c++;
        end
        dout_ready = 1'b1;
        chk("drain_in_budget", c < budget, 1'b1);
    endtask
    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
    initial begin
        int f0;
        tick(); tick();
        rst = 1'b0;
        run = 1;
        send(0, 32);
        wait_drain(200, 0);
        chk("lit_s0", cap[0], 32'd0);
`ifdef FFT_OUT_BITREV_EN
        chk("lit_s1", cap[1], 32'd32);
        chk("lit_s2", cap[2], 32'd16);
        chk("lit_s3", cap[3], 32'd48);
`else
        chk("lit_s1", cap[1], 32'd1);
        chk("lit_s2", cap[2], 32'd2);
        chk("lit_s3", cap[3], 32'd3);
`endif
        chk("lit_s63", cap[63], 32'd63);
        send(100, 32);
        wait_drain(400, 1);
        send(200, 32);
        for (int i = 0; i < 10; i++) begin
            pair_valid = 1'b1;
            set_pair(9000 + i);
            tick();
        end
        pair_valid = 1'b0;
        wait_drain(200, 0);
        send(300, 32);
        wait_drain(200, 0);
        chk("drop_sticky", drop_err, 1'b1);
        send(400, 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_drop_clr", drop_err, 1'b0);
        send(500, 32);
        wait_drain(200, 0);
        f0 = frames;
        for (int c = 0; c < 400 && !(frames == f0 + 1 && !m_fill); c++) begin
            pair_valid = 1'b1;
            set_pair(600 + c);
            tick();
        end
        pair_valid = 1'b0;
        chk("b2b_second_frame", frames == f0 + 1 && !m_fill, 1'b1);
        wait_drain(200, 0);
        chk("b2b_drop", drop_err, 1'b1);
        chk("b2b_frames", frames, f0 + 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
